// File: rtl/div_issue_ctrl_pkg.sv
// Shared definitions for the divide issue controller: state encoding, drain default
// and the HI/LO field bounds inside the divider result word.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDone  = 2'd2,
        StDrain = 2'd3
    } div_state_e;

    localparam int unsigned DrainCyclesDefault = 4;

    // div_result_i is {remainder, quotient}; remainder goes to HI, quotient to LO
    localparam int unsigned HiMsb = 63;
    localparam int unsigned HiLsb = 32;
    localparam int unsigned LoMsb = 31;
    localparam int unsigned LoLsb = 0;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/retire controller for a multi-cycle divider: starts the divider, freezes
// the front of the pipe while it runs, writes HI/LO on completion and drains after a flush.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid,
    input  logic        ex_div_signed,
    input  logic [31:0] ex_op1,
    input  logic [31:0] ex_op2,
    input  logic        ex_flush,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_wdata_o,
    output logic [31:0] lo_wdata_o
);

    localparam int unsigned CntW = ($clog2(DRAIN_CYCLES + 1) < 1) ? 1 :
                                   $clog2(DRAIN_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(DRAIN_CYCLES);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     op1_q, op1_d, op2_q, op2_d, hi_q, hi_d, lo_q, lo_d;
    logic            sgn_q, sgn_d;
    logic            issue, capture;

    assign issue   = (state_q == StIdle) && ex_div_valid && !ex_flush;
    // A flush on the ready cycle wins: the result is dropped
    assign capture = (state_q == StBusy) && div_ready_i && !ex_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (issue) state_d = StBusy;
            end
            StBusy: begin
                if (ex_flush) begin
                    state_d = StDrain;
                    cnt_d   = CntLoad;
                end else if (div_ready_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StDrain: begin
                if (cnt_q <= CntOne) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        op1_d = op1_q;
        op2_d = op2_q;
        sgn_d = sgn_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (issue) begin
            op1_d = ex_op1;
            op2_d = ex_op2;
            sgn_d = ex_div_signed;
        end
        if (capture) begin
            hi_d = div_result_i[HiMsb:HiLsb];
            lo_d = div_result_i[LoMsb:LoLsb];
        end
    end

    // Strobes are forced low while reset is asserted, independent of EX inputs
    always_comb begin
        stall_o     = 1'b0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        hilo_we_o   = 1'b0;
        if (rst) begin
            unique case (state_q)
                StIdle: begin
                    stall_o     = issue;
                    div_start_o = issue;
                end
                StBusy: begin
                    stall_o     = 1'b1;
                    div_annul_o = ex_flush;
                end
                StDone: begin
                    hilo_we_o = 1'b1;
                end
                StDrain: begin
                    stall_o     = ex_div_valid;
                    div_annul_o = 1'b1;
                end
                default: begin
                    stall_o = 1'b0;
                end
            endcase
        end
    end

    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign div_signed_o = sgn_q;
    assign hi_wdata_o   = hi_q;
    assign lo_wdata_o   = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl; the bench plays the divider (35-cycle latency, 3 for a
// zero divisor) and predicts every strobe per cycle from the issue/flush/drain rules.
module tb_div_issue_ctrl;

    localparam int DRAIN = 4;

    logic        clk;
    logic        rst;
    logic        ex_div_valid;
    logic        ex_div_signed;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic        ex_flush;
    logic        stall_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_annul_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        hilo_we_o;
    logic [31:0] hi_wdata_o;
    logic [31:0] lo_wdata_o;

    int checks;
    int failures;
    int starts_seen;
    int writes_seen;
    int exp_starts;
    int exp_writes;

    div_issue_ctrl #(
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_div_valid (ex_div_valid),
        .ex_div_signed(ex_div_signed),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_flush     (ex_flush),
        .stall_o      (stall_o),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_annul_o  (div_annul_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .hilo_we_o    (hilo_we_o),
        .hi_wdata_o   (hi_wdata_o),
        .lo_wdata_o   (lo_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference divider: truncating division, remainder takes the dividend's sign
    function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
        longint sa, sb, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    always @(negedge clk) begin
        if (div_start_o) starts_seen++;
        if (hilo_we_o) writes_seen++;
        check_eq("start_annul_excl", 64'(div_start_o & div_annul_o), 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One DIV from issue to retirement; flush_at = BUSY cycle index of the flush, 0 = none
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int flush_at);
        int          lat;
        int          stalls;
        bit          flushed;
        logic [63:0] res;
        lat     = (b == 32'd0) ? 3 : 35;
        res     = div_model(a, b, sgn);
        flushed = 1'b0;
        stalls  = 0;

        ex_div_valid  = 1'b1;
        ex_div_signed = sgn;
        ex_op1        = a;
        ex_op2        = b;
        ex_flush      = 1'b0;
        div_ready_i   = 1'b0;
        @(negedge clk);
        check_eq("issue_start", 64'(div_start_o), 64'd1);
        check_eq("issue_stall", 64'(stall_o), 64'd1);
        if (stall_o) stalls++;
        exp_starts++;
        step();

        for (int k = 1; k <= lat; k++) begin
            ex_op1       = $urandom;
            ex_op2       = $urandom;
            div_ready_i  = (k == lat);
            div_result_i = (k == lat) ? res : {$urandom, $urandom};
            ex_flush     = (k == flush_at);
            @(negedge clk);
            check_eq("busy_stall", 64'(stall_o), 64'd1);
            check_eq("busy_start", 64'(div_start_o), 64'd0);
            check_eq("busy_annul", 64'(div_annul_o), 64'(k == flush_at));
            check_eq("busy_we", 64'(hilo_we_o), 64'd0);
            check_eq("busy_ops", {div_op1_o, div_op2_o}, {a, b});
            check_eq("busy_sgn", 64'(div_signed_o), 64'(sgn));
            if (stall_o) stalls++;
            step();
            if (k == flush_at) begin
                flushed = 1'b1;
                break;
            end
        end
        div_ready_i = 1'b0;
        ex_flush    = 1'b0;

        if (flushed) begin
            for (int d = 0; d < DRAIN; d++) begin
                ex_div_valid = 1'($urandom_range(0, 1));
                div_ready_i  = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_eq("drain_annul", 64'(div_annul_o), 64'd1);
                check_eq("drain_stall", 64'(stall_o), 64'(ex_div_valid));
                check_eq("drain_we", 64'(hilo_we_o), 64'd0);
                step();
            end
            ex_div_valid = 1'b0;
            div_ready_i  = 1'b0;
            @(negedge clk);
            check_eq("drain_exit_annul", 64'(div_annul_o), 64'd0);
            check_eq("drain_exit_we", 64'(hilo_we_o), 64'd0);
            step();
        end else begin
            // Instruction still sits in EX during DONE; a flush here must not cancel the write
            ex_flush = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("done_we", 64'(hilo_we_o), 64'd1);
            check_eq("done_stall", 64'(stall_o), 64'd0);
            check_eq("done_start", 64'(div_start_o), 64'd0);
            check_eq("done_annul", 64'(div_annul_o), 64'd0);
            check_eq("done_hilo", {hi_wdata_o, lo_wdata_o}, res);
            check_eq("stall_cycles", 64'(stalls), 64'(lat + 1));
            exp_writes++;
            step();
            ex_flush     = 1'b0;
            ex_div_valid = 1'b0;
        end
    endtask

    // Cycles where nothing may issue: no valid, or valid killed by flush
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            ex_div_valid = 1'($urandom_range(0, 1));
            ex_flush     = ex_div_valid ? 1'b1 : 1'($urandom_range(0, 1));
            div_ready_i  = 1'($urandom_range(0, 1));
            div_result_i = {$urandom, $urandom};
            @(negedge clk);
            check_eq("idle_start", 64'(div_start_o), 64'd0);
            check_eq("idle_stall", 64'(stall_o), 64'd0);
            check_eq("idle_annul", 64'(div_annul_o), 64'd0);
            check_eq("idle_we", 64'(hilo_we_o), 64'd0);
            step();
        end
        ex_div_valid = 1'b0;
        ex_flush     = 1'b0;
        div_ready_i  = 1'b0;
    endtask

    initial begin
        logic [31:0] a, b, hi_keep, lo_keep;
        logic        s;
        int          lat, f, fa;
        checks = 0; failures = 0;
        starts_seen = 0; writes_seen = 0; exp_starts = 0; exp_writes = 0;
        rst = 1'b0;
        ex_div_valid = 1'b1; ex_div_signed = 1'b1; ex_op1 = 32'h1234; ex_op2 = 32'h5;
        ex_flush = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
        #2;
        check_eq("rst_stall", 64'(stall_o), 64'd0);
        check_eq("rst_start", 64'(div_start_o), 64'd0);
        check_eq("rst_regs", {div_op1_o, div_op2_o}, 64'd0);
        check_eq("rst_hilo", {hi_wdata_o, lo_wdata_o}, 64'd0);
        check_eq("rst_flags", {61'd0, div_signed_o, div_annul_o, hilo_we_o}, 64'd0);
        ex_div_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        idle_cycles(3);

        run_div(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 0);
        check_eq("neg7_div_2", {hi_wdata_o, lo_wdata_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_div(32'h0000_000A, 32'h0000_0000, 1'b0, 0);
        check_eq("div_by_zero", {hi_wdata_o, lo_wdata_o}, 64'd0);

        run_div($urandom, $urandom | 32'h1, 1'b1, 10);
        run_div(32'd100, 32'd7, 1'b0, 0);
        check_eq("after_flush_div", {hi_wdata_o, lo_wdata_o}, {32'd2, 32'd14});

        run_div(32'd55, 32'd3, 1'b0, 35);
        check_eq("flush_on_ready_kept", {hi_wdata_o, lo_wdata_o}, {32'd2, 32'd14});

        run_div(32'd81, 32'd9, 1'b0, 0);
        run_div(32'hFFFF_FF00, 32'd16, 1'b1, 0);
        check_eq("back_to_back", {hi_wdata_o, lo_wdata_o}, 64'h0000_0000_FFFF_FFF0);
        check_eq("b2b_starts", 64'(starts_seen), 64'(exp_starts));

        // Reset in the middle of BUSY abandons the operation
        ex_div_valid = 1'b1; ex_div_signed = 1'b0; ex_op1 = 32'd9; ex_op2 = 32'd2;
        exp_starts++;
        step();
        for (int i = 0; i < 5; i++) step();
        hi_keep = hi_wdata_o;
        rst = 1'b0;
        #1;
        check_eq("midrst_strobes", {60'd0, stall_o, div_start_o, div_annul_o, hilo_we_o},
                 64'd0);
        check_eq("midrst_ops", {div_op1_o, div_op2_o}, 64'd0);
        check_eq("midrst_hilo", {hi_wdata_o, lo_wdata_o}, 64'd0);
        check_eq("midrst_sgn", 64'(div_signed_o), 64'd0);
        step();
        rst = 1'b1;
        ex_div_valid = 1'b0;
        idle_cycles(40);
        check_eq("midrst_no_write", {hi_wdata_o, lo_wdata_o}, 64'd0);
        check_eq("midrst_writes", 64'(writes_seen), 64'(exp_writes));

        for (int n = 0; n < 30; n++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            s   = 1'($urandom_range(0, 1));
            lat = (b == 32'd0) ? 3 : 35;
            f   = $urandom_range(0, 4);
            fa  = (f == 0) ? lat : (f == 1) ? $urandom_range(1, lat - 1) : 0;
            hi_keep = hi_wdata_o;
            lo_keep = lo_wdata_o;
            run_div(a, b, s, fa);
            if (fa != 0) check_eq("rand_flush_kept", {hi_wdata_o, lo_wdata_o},
                                  {hi_keep, lo_keep});
            idle_cycles($urandom_range(0, 3));
        end

        check_eq("total_starts", 64'(starts_seen), 64'(exp_starts));
        check_eq("total_writes", 64'(writes_seen), 64'(exp_writes));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4: cycles spent discarding divider activity after a flush.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_div_valid  in  1  EX-stage instruction is DIV/DIVU.
REQ-005 SHALL have port ex_div_signed  in  1  1 = DIV, 0 = DIVU.
REQ-006 SHALL have ports ex_op1 and ex_op2  in  32 each  dividend and divisor.
REQ-007 SHALL have port ex_flush  in  1  exception/branch flush of EX.
REQ-008 SHALL have port stall_o  out  1  freeze IF..EX.
REQ-009 SHALL have port div_start_o  out  1  start pulse to divider.
REQ-010 SHALL have port div_signed_o  out  1  signed-mode select to divider.
REQ-011 SHALL have ports div_op1_o and div_op2_o  out  32 each  latched operands to divider.
REQ-012 SHALL have port div_annul_o  out  1  abort to divider.
REQ-013 SHALL have port div_result_i  in  64  {remainder, quotient} from divider.
REQ-014 SHALL have port div_ready_i  in  1  one-cycle result-valid pulse from divider.
REQ-015 SHALL have port hilo_we_o  out  1  HI/LO write strobe.
REQ-016 SHALL have ports hi_wdata_o and lo_wdata_o  out  32 each  HI/LO write data.

Function
REQ-017 SHALL implement states IDLE, BUSY, DONE, DRAIN.
REQ-018 IDLE with ex_div_valid=1 and ex_flush=0: div_start_o=1 (combinational, that cycle only); operands and sign registered to div_op*_o and div_signed_o; next state BUSY.
REQ-019 div_op1_o, div_op2_o and div_signed_o SHALL hold stable from the issue edge until the state leaves BUSY.
REQ-020 stall_o SHALL equal 1 in IDLE when ex_div_valid=1 and ex_flush=0, 1 throughout BUSY, 0 in DONE, and 1 in DRAIN only when ex_div_valid=1.
REQ-021 BUSY with div_ready_i=1: register hi_wdata_o=div_result_i[63:32] and lo_wdata_o=div_result_i[31:0]; next state DONE.
REQ-022 DONE: hilo_we_o=1 for exactly this one cycle; next state IDLE unconditionally, so the still-present ex_div_valid is not re-issued.
REQ-023 No fixed latency SHALL be assumed; with the team divider, div_ready_i arrives 35 cycles after start (3 for a zero divisor).
REQ-024 ex_flush=1 in BUSY (including the div_ready_i cycle) SHALL: suppress the HI/LO write, assert div_annul_o, and go to DRAIN.
REQ-025 DRAIN: div_annul_o=1 for DRAIN_CYCLES cycles (down-counter), div_ready_i ignored, then IDLE.
REQ-026 ex_flush=1 in IDLE together with ex_div_valid=1 SHALL issue nothing.
REQ-027 ex_flush=1 in DONE SHALL still complete the write, since the instruction has already retired its result.
REQ-028 div_start_o and div_annul_o SHALL never be asserted in the same cycle.
REQ-029 div_ready_i outside BUSY SHALL be ignored.

Reset
REQ-030 On rst=0 (asynchronous assert, synchronous deassert at the parent): state=IDLE, drain counter=0, div_op*_o=0, div_signed_o=0, hi_wdata_o=0, lo_wdata_o=0; combinational outputs stall_o, div_start_o, div_annul_o and hilo_we_o SHALL then evaluate to 0.
REQ-031 Reset mid-BUSY SHALL abandon the operation with no HI/LO write; the divider is reset by the same rst.

Structure
REQ-032 State encoding, DRAIN_CYCLES default and HI/LO field bounds SHALL live in the shared defines package.
REQ-033 SHALL contain no sub-module; the divider is instantiated beside it in the EX-stage parent.

Verification
REQ-034 The bench SHALL check: DIV 0xFFFFFFF9 / 0x00000002 -> stall for 36 cycles, one hilo_we_o pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFD.
REQ-035 The bench SHALL check: DIVU 0x0000000A / 0x00000000 -> ready after 3 cycles, HI=0, LO=0, single write.
REQ-036 The bench SHALL check: ex_flush at BUSY cycle 10 -> no hilo_we_o, div_annul_o high for 4 cycles, next DIV issues normally.
REQ-037 The bench SHALL check: ex_flush coincident with div_ready_i -> no write; DRAIN entered.
REQ-038 The bench SHALL check: back-to-back DIVs -> second start occurs after DONE with no duplicate issue of the first.
REQ-039 The bench SHALL check: rst=0 mid-BUSY -> all outputs 0 immediately, no write after release.
